dmux_stream: RTL and testbench

//  Registered, parametrised 1-to-NCH demultiplexer with valid/ready handshaking.

---
 rtl/dmux_stream_pkg.sv | 24 ++
 rtl/dmux_stream_if.sv | 27 ++
 rtl/dmux_chan_reg.sv | 68 ++++++
 rtl/dmux_stream.sv | 84 ++++++++
 tb/tb_dmux_stream.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmux_stream_pkg.sv
// Shared constants, channel-state encoding and a saturating counter helper
// for the dmux_stream stream demultiplexer.
package dmux_pkg;

    localparam int DMUX_WIDTH_DEF = 24;
    localparam int DMUX_NCH_DEF   = 2;
    localparam int DMUX_CNT_W     = 16;

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_e;

    function automatic logic [DMUX_CNT_W-1:0] sat_inc(input logic [DMUX_CNT_W-1:0] v);
        logic [DMUX_CNT_W-1:0] r;
        if (v == {DMUX_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(DMUX_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/dmux_stream_if.sv
// Input stream plus per-channel output streams of dmux_stream; the producer/
// consumer side uses master, the demultiplexer uses slave.
interface dmux_stream_if #(
    parameter int WIDTH = 24,
    parameter int NCH   = 2
);
    localparam int SELW = $clog2(NCH);

    logic [WIDTH-1:0]     in_data;
    logic [SELW-1:0]      in_sel;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*WIDTH-1:0] out_data;
    logic [NCH-1:0]       out_valid;
    logic [NCH-1:0]       out_ready;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/dmux_chan_reg.sv
// One output slot of the demultiplexer: a state bit and a data register that
// accepts a push when empty or when its current word is popped in the same cycle.
module dmux_chan_reg
    import dmux_pkg::*;
#(
    parameter int WIDTH     = DMUX_WIDTH_DEF,
    parameter bit HOLD_LAST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    ch_state_e        state_r;
    ch_state_e        state_s;
    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] data_s;

    // Slot state and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= CH_EMPTY;
            data_r  <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
        end
    end

    // Next state; a push into a FULL slot only counts when the old word leaves.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        case (state_r)
            CH_EMPTY: begin
                if (push) begin
                    state_s = CH_FULL;
                    data_s  = push_data;
                end else begin
                    state_s = CH_EMPTY;
                end
            end
            CH_FULL: begin
                if (pop && push) begin
                    state_s = CH_FULL;
                    data_s  = push_data;
                end else if (pop) begin
                    state_s = CH_EMPTY;
                    data_s  = HOLD_LAST ? data_r : {WIDTH{1'b0}};
                end else begin
                    state_s = CH_FULL;
                end
            end
            default: begin
                state_s = CH_EMPTY;
                data_s  = {WIDTH{1'b0}};
            end
        endcase
    end

    assign valid = (state_r == CH_FULL);
    assign data  = data_r;

endmodule

// File: rtl/dmux_stream.sv
// Registered 1-to-NCH stream demultiplexer: routes each accepted word to the
// slot named by in_sel, drops and counts words addressed beyond the last slot.
module dmux_stream
    import dmux_pkg::*;
#(
    parameter int WIDTH     = DMUX_WIDTH_DEF,
    parameter int NCH       = DMUX_NCH_DEF,
    parameter bit HOLD_LAST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmux_stream_if.slave          bus,
    output logic                  sel_err,
    output logic [DMUX_CNT_W-1:0] drop_cnt
);

    localparam int SELW = $clog2(NCH);
    localparam logic [SELW:0] NCH_V = (SELW+1)'(NCH);

    logic                  sel_oob_s;
    logic                  in_ready_s;
    logic                  drop_s;
    logic [NCH-1:0]        push_s;
    logic [NCH-1:0]        pop_s;
    logic [NCH-1:0]        chan_valid_s;
    logic [NCH*WIDTH-1:0]  chan_data_s;
    logic                  sel_err_r;
    logic [DMUX_CNT_W-1:0] drop_cnt_r;

    // Select decode and acceptance: out-of-range words are always taken.
    always_comb begin
        sel_oob_s  = ({1'b0, bus.in_sel} >= NCH_V);
        in_ready_s = 1'b1;
        if (!sel_oob_s) begin
            in_ready_s = !chan_valid_s[bus.in_sel] || bus.out_ready[bus.in_sel];
        end else begin
            in_ready_s = 1'b1;
        end
        drop_s = bus.in_valid && sel_oob_s;
        push_s = {NCH{1'b0}};
        pop_s  = {NCH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            push_s[k] = bus.in_valid && in_ready_s && !sel_oob_s && (int'(bus.in_sel) == k);
            pop_s[k]  = chan_valid_s[k] && bus.out_ready[k];
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        dmux_chan_reg #(
            .WIDTH     (WIDTH),
            .HOLD_LAST (HOLD_LAST)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push_s[k]),
            .pop       (pop_s[k]),
            .push_data (bus.in_data),
            .valid     (chan_valid_s[k]),
            .data      (chan_data_s[k*WIDTH +: WIDTH])
        );
    end

    // Drop reporting: one-cycle error pulse and a saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r  <= 1'b0;
            drop_cnt_r <= {DMUX_CNT_W{1'b0}};
        end else begin
            sel_err_r <= drop_s;
            if (drop_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = chan_valid_s;
    assign bus.out_data  = chan_data_s;
    assign sel_err       = sel_err_r;
    assign drop_cnt      = drop_cnt_r;

endmodule

// File: tb/tb_dmux_stream.sv
// Scoreboard bench: two demultiplexers (2 slots hold-last, 3 slots clear-on-pop)
// driven by directed and random traffic against a queue-based reference model.
module tb_dmux_stream;

    typedef logic [23:0] word_t;

    logic clk;
    logic rst_n;
    logic        sel_err_a, sel_err_b;
    logic [15:0] drop_cnt_a, drop_cnt_b;

    dmux_stream_if #(.WIDTH(24), .NCH(2)) ifa ();
    dmux_stream_if #(.WIDTH(24), .NCH(3)) ifb ();

    dmux_stream #(.WIDTH(24), .NCH(2), .HOLD_LAST(1'b1)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (ifa),
        .sel_err  (sel_err_a),
        .drop_cnt (drop_cnt_a)
    );

    dmux_stream #(.WIDTH(24), .NCH(3), .HOLD_LAST(1'b0)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (ifb),
        .sel_err  (sel_err_b),
        .drop_cnt (drop_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    word_t sbq [6][$];
    word_t last_w [6];
    word_t nx_data [2];
    logic [1:0] nx_sel [2];
    logic       nx_valid [2];
    logic [2:0] nx_rdy [2];
    logic [1:0] drv_sel [2];
    logic       drv_valid [2];
    logic [2:0] drv_rdy [2];
    logic       pend_push [2];
    logic       pend_drop [2];
    int         pend_ch [2];
    word_t      pend_word [2];
    logic [15:0] exp_cnt [2];

    function automatic int nch(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic logic [2:0] ov(input int d);
        return (d == 0) ? {1'b0, ifa.out_valid} : ifb.out_valid;
    endfunction

    function automatic word_t od(input int d, input int k);
        logic [71:0] t;
        t = (d == 0) ? {24'h000000, ifa.out_data} : ifb.out_data;
        return t[k*24 +: 24];
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp_v);
        end
    endtask

    task automatic apply_nx();
        ifa.in_data   = nx_data[0];
        ifa.in_sel    = nx_sel[0][0];
        ifa.in_valid  = nx_valid[0];
        ifa.out_ready = nx_rdy[0][1:0];
        ifb.in_data   = nx_data[1];
        ifb.in_sel    = nx_sel[1];
        ifb.in_valid  = nx_valid[1];
        ifb.out_ready = nx_rdy[1];
        drv_sel[0]    = {1'b0, nx_sel[0][0]};
        drv_sel[1]    = nx_sel[1];
        drv_rdy[0]    = {1'b0, nx_rdy[0][1:0]};
        drv_rdy[1]    = nx_rdy[1];
        drv_valid[0]  = nx_valid[0];
        drv_valid[1]  = nx_valid[1];
    endtask

    task automatic set_idle(input int d, input logic [2:0] rdy);
        nx_valid[d] = 1'b0;
        nx_sel[d]   = 2'd0;
        nx_data[d]  = 24'h000000;
        nx_rdy[d]   = rdy;
    endtask

    task automatic set_push(input int d, input logic [1:0] sel, input word_t w, input logic [2:0] rdy);
        nx_valid[d] = 1'b1;
        nx_sel[d]   = sel;
        nx_data[d]  = w;
        nx_rdy[d]   = rdy;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 6; i++) begin
            sbq[i].delete();
            last_w[i] = 24'h000000;
        end
        for (int d = 0; d < 2; d++) begin
            pend_push[d] = 1'b0;
            pend_drop[d] = 1'b0;
            pend_ch[d]   = 0;
            pend_word[d] = 24'h000000;
            exp_cnt[d]   = 16'h0000;
            set_idle(d, 3'b000);
        end
    endtask

    // One clock: commit last cycle's accepted word, then drive and judge acceptance.
    task automatic step();
        int    sel;
        logic  er;
        logic  act_se;
        logic  act_rdy;
        logic [15:0] act_cnt;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (pend_push[d]) sbq[d*3 + pend_ch[d]].push_back(pend_word[d]);
            if (pend_drop[d] && exp_cnt[d] != 16'hFFFF) exp_cnt[d] = exp_cnt[d] + 16'd1;
            act_se  = (d == 0) ? sel_err_a : sel_err_b;
            act_cnt = (d == 0) ? drop_cnt_a : drop_cnt_b;
            chk("sel_err", d, 32'(act_se), 32'(pend_drop[d]));
            chk("drop_cnt", d, 32'(act_cnt), 32'(exp_cnt[d]));
            pend_push[d] = 1'b0;
            pend_drop[d] = 1'b0;
        end
        apply_nx();
        #1;
        for (int d = 0; d < 2; d++) begin
            sel = int'(drv_sel[d]);
            if (sel >= nch(d)) er = 1'b1;
            else er = (sbq[d*3 + sel].size() == 0) || drv_rdy[d][sel];
            act_rdy = (d == 0) ? ifa.in_ready : ifb.in_ready;
            chk("in_ready", d, 32'(act_rdy), 32'(er));
            if (drv_valid[d] && er) begin
                if (sel >= nch(d)) begin
                    pend_drop[d] = 1'b1;
                end else begin
                    pend_push[d] = 1'b1;
                    pend_ch[d]   = sel;
                    pend_word[d] = nx_data[d];
                end
            end
        end
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            for (int d = 0; d < 2; d++) begin
                nx_valid[d] = ($urandom_range(0, 3) != 0);
                nx_sel[d]   = 2'($urandom_range(0, (d == 0) ? 1 : 3));
                nx_data[d]  = 24'($urandom);
                nx_rdy[d]   = 3'($urandom);
            end
            step();
        end
    endtask

    task automatic check_reset_state();
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", d, 32'(ov(d)), 32'd0);
            for (int k = 0; k < nch(d); k++) chk("rst_out_data", d, 32'(od(d, k)), 32'd0);
        end
        chk("rst_drop_cnt", 0, 32'(drop_cnt_a), 32'd0);
        chk("rst_drop_cnt", 1, 32'(drop_cnt_b), 32'd0);
        chk("rst_sel_err", 0, 32'(sel_err_a), 32'd0);
        chk("rst_sel_err", 1, 32'(sel_err_b), 32'd0);
    endtask

    // Monitor: compares each slot against the scoreboard and retires popped words.
    initial begin : monitor
        logic [2:0] v;
        word_t      exp_idle;
        int         idx;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    v = ov(d);
                    for (int k = 0; k < nch(d); k++) begin
                        idx = d*3 + k;
                        chk("out_valid", d, 32'(v[k]), 32'(sbq[idx].size() != 0));
                        if (sbq[idx].size() != 0) begin
                            chk("out_data", d, 32'(od(d, k)), 32'(sbq[idx][0]));
                            if (drv_rdy[d][k]) last_w[idx] = sbq[idx].pop_front();
                        end else begin
                            exp_idle = (d == 0) ? last_w[idx] : 24'h000000;
                            chk("idle_data", d, 32'(od(d, k)), 32'(exp_idle));
                        end
                    end
                end
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        clear_model();
        apply_nx();
        #1;
        check_reset_state();
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Single word to slot 1 with every consumer ready.
        set_push(0, 2'd1, 24'hABCDEF, 3'b111);
        step();
        set_idle(0, 3'b111);
        step();
        step();

        // Slot 0 stalled: second word waits while slot 1 traffic still flows.
        set_push(0, 2'd0, 24'h000001, 3'b110);
        step();
        set_push(0, 2'd0, 24'h000002, 3'b110);
        step();
        step();
        set_push(0, 2'd1, 24'h0000AA, 3'b110);
        step();
        set_push(0, 2'd0, 24'h000002, 3'b111);
        step();
        set_idle(0, 3'b111);
        step();
        step();

        // Back-to-back stream of 100 words into slot 0.
        for (int i = 0; i < 100; i++) begin
            set_push(0, 2'd0, 24'(i), 3'b111);
            step();
        end
        set_idle(0, 3'b111);
        step();
        step();

        rand_cycles(400);

        // Asynchronous reset with slot 0 full and a nonzero drop count.
        set_push(0, 2'd0, 24'h5A5A5A, 3'b000);
        set_push(1, 2'd3, 24'h777777, 3'b000);
        step();
        set_idle(0, 3'b000);
        set_idle(1, 3'b000);
        step();
        chk("pre_reset_full", 0, 32'(ov(0) & 3'b001), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        clear_model();
        apply_nx();
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Single out-of-range word, then saturate the drop counter.
        set_push(1, 2'd3, 24'h111111, 3'b111);
        step();
        set_idle(1, 3'b111);
        step();
        step();
        for (int i = 0; i < 65540; i++) begin
            set_push(1, 2'd3, 24'(i), 3'b111);
            step();
        end
        set_idle(1, 3'b111);
        step();
        chk("drop_sat", 1, 32'(drop_cnt_b), 32'h0000FFFF);

        // Pop without refill: hold-last versus clear-on-pop.
        set_push(0, 2'd0, 24'h123456, 3'b000);
        set_push(1, 2'd0, 24'h123456, 3'b000);
        step();
        set_idle(0, 3'b001);
        set_idle(1, 3'b001);
        step();
        set_idle(0, 3'b000);
        set_idle(1, 3'b000);
        step();
        chk("hold_last1_data", 0, 32'(od(0, 0)), 32'h00123456);
        chk("hold_last0_data", 1, 32'(od(1, 0)), 32'h00000000);
        chk("hold_valid", 0, 32'(ov(0) & 3'b001), 32'd0);
        chk("hold_valid", 1, 32'(ov(1) & 3'b001), 32'd0);

        rand_cycles(300);
        set_idle(0, 3'b111);
        set_idle(1, 3'b111);
        step();
        step();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
